// File: rtl/mem_writeback.sv
// ---------------------------------------------------------------------------
// mem_writeback : memory / writeback stage of the c16 pipeline.
//
// Sits directly after the executor. ALU results are registered onto the
// register-file write port. Stores go straight out to RAM port B in the
// accept cycle. Loads issue their address, stall the executor for
// LOAD_LATENCY cycles, and then write the returned word back.
//
// Optional feature macro: WB_FWD_EN
//   When defined, the fwd_* ports expose the combinational next-cycle values
//   of wb_en/wb_dest/wb_value so the decoder can bypass a cycle early.
//   When undefined, those ports and their logic are absent.
//
// Ports
//   clk, reset                 pipeline clock, synchronous active-high reset
//   ex_valid/ex_op/ex_dest     executor result handshake and op decode
//   ex_value                   ALU result, or word address for LD/ST
//   ex_wen                     register write request (ALU only)
//   ex_store_data              store data (ST only)
//   ex_ready                   stage accepts ex_valid this cycle
//   mem_addr/mem_wdata/mem_wren/mem_rdata   RAM port B
//   wb_dest/wb_value/wb_en     register-file write port (registered)
//   busy                       a load is outstanding
//   fwd_en/fwd_dest/fwd_value  (WB_FWD_EN only) next-cycle writeback values
// ---------------------------------------------------------------------------
module mem_writeback #(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 16,
    parameter int REG_AW       = 4,
    parameter int LOAD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic [1:0]        ex_op,
    input  logic [REG_AW-1:0] ex_dest,
    input  logic [DATA_W-1:0] ex_value,
    input  logic              ex_wen,
    input  logic [DATA_W-1:0] ex_store_data,
    output logic              ex_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [REG_AW-1:0] wb_dest,
    output logic [DATA_W-1:0] wb_value,
    output logic              wb_en,
`ifdef WB_FWD_EN
    output logic              busy,
    output logic              fwd_en,
    output logic [REG_AW-1:0] fwd_dest,
    output logic [DATA_W-1:0] fwd_value
`else
    output logic              busy
`endif
);

    localparam int CNT_W = $clog2(LOAD_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LOAD_LATENCY - 1);

    localparam logic [1:0] OP_ALU = 2'b00;
    localparam logic [1:0] OP_LD  = 2'b01;
    localparam logic [1:0] OP_ST  = 2'b10;

    typedef enum logic {
        IDLE,
        LD_WAIT
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  wait_cnt, wait_cnt_nxt;
    logic [ADDR_W-1:0] ld_addr;
    logic [REG_AW-1:0] ld_dest;
    logic              ld_latch;
    logic              accept;

    logic              wb_en_nxt;
    logic [REG_AW-1:0] wb_dest_nxt;
    logic [DATA_W-1:0] wb_value_nxt;

    // Holding ex_ready low during reset keeps anything presented in that
    // window from being accepted or reaching the RAM.
    always_comb begin
        ex_ready = (state == IDLE) && !reset;
        accept   = ex_valid && ex_ready;
        busy     = (state != IDLE);
    end

    // RAM port B. While a load waits, the address is pinned to the latched
    // load address because upstream is free to change ex_value.
    always_comb begin
        mem_addr  = (state == LD_WAIT) ? ld_addr : ex_value[ADDR_W-1:0];
        mem_wdata = ex_store_data;
        mem_wren  = accept && (ex_op == OP_ST);
    end

    // Next-state and next writeback values. wb_en defaults to 0 so every
    // write is a one-cycle pulse unless another write follows immediately.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        wb_en_nxt    = 1'b0;
        wb_dest_nxt  = wb_dest;
        wb_value_nxt = wb_value;
        ld_latch     = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (ex_op)
                        OP_ALU: begin
                            wb_en_nxt    = ex_wen;
                            wb_dest_nxt  = ex_dest;
                            wb_value_nxt = ex_value;
                        end
                        OP_LD: begin
                            state_nxt    = LD_WAIT;
                            wait_cnt_nxt = CNT_INIT;
                            ld_latch     = 1'b1;
                        end
                        // ST writes RAM combinationally; reserved op is dropped.
                        default: ;
                    endcase
                end
            end
            LD_WAIT: begin
                if (wait_cnt == '0) begin
                    state_nxt    = IDLE;
                    wb_en_nxt    = 1'b1;
                    wb_dest_nxt  = ld_dest;
                    wb_value_nxt = mem_rdata;
                end else begin
                    wait_cnt_nxt = wait_cnt - CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Reset takes priority, so a load caught in LD_WAIT is simply abandoned.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
            wb_en    <= 1'b0;
            wb_dest  <= '0;
            wb_value <= '0;
            ld_addr  <= '0;
            ld_dest  <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            wb_en    <= wb_en_nxt;
            wb_dest  <= wb_dest_nxt;
            wb_value <= wb_value_nxt;
            if (ld_latch) begin
                ld_addr <= ex_value[ADDR_W-1:0];
                ld_dest <= ex_dest;
            end
        end
    end

`ifdef WB_FWD_EN
    always_comb begin
        fwd_en    = reset ? 1'b0 : wb_en_nxt;
        fwd_dest  = reset ? '0   : wb_dest_nxt;
        fwd_value = reset ? '0   : wb_value_nxt;
    end
`endif

endmodule

// File: tb/tb_mem_writeback.sv
module tb_mem_writeback;

    logic        clk;
    logic        reset;
    logic        ex_valid;
    logic [1:0]  ex_op;
    logic [3:0]  ex_dest;
    logic [15:0] ex_value;
    logic        ex_wen;
    logic [15:0] ex_store_data;
    logic        ex_ready;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_wren;
    logic [15:0] mem_rdata;
    logic [3:0]  wb_dest;
    logic [15:0] wb_value;
    logic        wb_en;
    logic        busy;
`ifdef WB_FWD_EN
    logic        fwd_en;
    logic [3:0]  fwd_dest;
    logic [15:0] fwd_value;
`endif

    mem_writeback #(
        .DATA_W(16), .ADDR_W(16), .REG_AW(4), .LOAD_LATENCY(1)
    ) dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_op(ex_op), .ex_dest(ex_dest),
        .ex_value(ex_value), .ex_wen(ex_wen), .ex_store_data(ex_store_data),
        .ex_ready(ex_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren),
        .mem_rdata(mem_rdata),
        .wb_dest(wb_dest), .wb_value(wb_value), .wb_en(wb_en),
`ifdef WB_FWD_EN
        .busy(busy),
        .fwd_en(fwd_en), .fwd_dest(fwd_dest), .fwd_value(fwd_value)
`else
        .busy(busy)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // RAM port B model: registered read, one cycle latency.
    logic [15:0] ram [0:255];
    logic [15:0] rd_q;
    always @(posedge clk) begin
        if (mem_wren) ram[mem_addr[7:0]] <= mem_wdata;
        rd_q <= ram[mem_addr[7:0]];
    end
    assign mem_rdata = rd_q;

    // Scoreboard of expected register-file writes, in retire order.
    typedef struct {
        logic [3:0]  dest;
        logic [15:0] value;
    } wb_t;
    wb_t exp_q[$];
    logic [15:0] exp_mem [0:255];

    always @(negedge clk) begin
        wb_t e;
        if (wb_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("wb_unexpected", {31'd0, wb_en}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("wb_dest_value", {12'd0, wb_dest, wb_value}, {12'd0, e.dest, e.value});
            end
        end
    end

`ifdef WB_FWD_EN
    logic        pf_vld = 1'b0;
    logic        pf_en;
    logic [3:0]  pf_dest;
    logic [15:0] pf_value;
    always @(negedge clk) begin
        if (pf_vld) begin
            chk("fwd_en", {31'd0, wb_en}, {31'd0, pf_en});
            if (pf_en) chk("fwd_dv", {12'd0, wb_dest, wb_value}, {12'd0, pf_dest, pf_value});
        end
        pf_vld   <= 1'b1;
        pf_en    <= fwd_en;
        pf_dest  <= fwd_dest;
        pf_value <= fwd_value;
    end
`endif

    // Present one op, wait (bounded) for acceptance, check the accept-cycle
    // RAM outputs, and record the expected writeback. Called just after a
    // rising edge; returns just after the edge that accepted the op.
    task automatic drive(input logic [1:0] op, input logic [3:0] dest,
                         input logic [15:0] value, input logic wen,
                         input logic [15:0] sdata, input logic exp_wren,
                         input bit push);
        bit done = 0;
        wb_t e;
        ex_valid = 1'b1; ex_op = op; ex_dest = dest; ex_value = value;
        ex_wen = wen; ex_store_data = sdata;
        for (int i = 0; i < 10 && !done; i++) begin
            @(negedge clk);
            if (ex_ready) begin
                done = 1;
                chk("acc_wren", {31'd0, mem_wren}, {31'd0, exp_wren});
                chk("acc_addr", {16'd0, mem_addr}, {16'd0, value});
                if (op == 2'b10) chk("acc_wdata", {16'd0, mem_wdata}, {16'd0, sdata});
                if (op == 2'b10) exp_mem[value[7:0]] = sdata;
                if (push && op == 2'b00 && wen) begin
                    e.dest = dest; e.value = value; exp_q.push_back(e);
                end
                if (push && op == 2'b01) begin
                    e.dest = dest; e.value = exp_mem[value[7:0]]; exp_q.push_back(e);
                end
            end
            @(posedge clk); #1;
        end
        if (!done) chk("accept_timeout", {31'd0, ex_ready}, 32'd1);
        ex_valid = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [3:0]  dest;
        logic [15:0] value;
        logic        wen;
        logic [15:0] sdata;
        logic        exp_wren;
    } vec_t;
    vec_t tbl [0:10];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{2'b00, 4'd3, 16'h1234, 1'b1, 16'h0000, 1'b0};
        tbl[1]  = '{2'b10, 4'd0, 16'h0040, 1'b0, 16'hBEEF, 1'b1};
        tbl[2]  = '{2'b01, 4'd2, 16'h0040, 1'b0, 16'h0000, 1'b0};
        tbl[3]  = '{2'b00, 4'd5, 16'h0007, 1'b1, 16'h0000, 1'b0};
        tbl[4]  = '{2'b00, 4'd6, 16'hAAAA, 1'b0, 16'h0000, 1'b0};
        tbl[5]  = '{2'b11, 4'd4, 16'h0042, 1'b1, 16'h5A5A, 1'b0};
        tbl[6]  = '{2'b10, 4'd0, 16'h0041, 1'b0, 16'h1357, 1'b1};
        tbl[7]  = '{2'b00, 4'd7, 16'h7777, 1'b1, 16'h0000, 1'b0};
        tbl[8]  = '{2'b01, 4'd8, 16'h0041, 1'b0, 16'h0000, 1'b0};
        tbl[9]  = '{2'b01, 4'd1, 16'h0040, 1'b0, 16'h0000, 1'b0};
        tbl[10] = '{2'b00, 4'd8, 16'hFFFF, 1'b1, 16'h0000, 1'b0};
        for (int i = 0; i < 256; i++) begin
            ram[i] = 16'h0000;
            exp_mem[i] = 16'h0000;
        end

        // Reset, with a store presented that must not reach the RAM.
        reset = 1'b1; ex_valid = 1'b1; ex_op = 2'b10; ex_dest = 4'd0;
        ex_value = 16'h0010; ex_wen = 1'b1; ex_store_data = 16'h5555;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_wren", {31'd0, mem_wren}, 32'd0);
        chk("rst_wb_en", {31'd0, wb_en}, 32'd0);
        chk("rst_wb_dest", {28'd0, wb_dest}, 32'd0);
        chk("rst_wb_value", {16'd0, wb_value}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0; ex_valid = 1'b0;
        @(negedge clk);
        chk("rst_ready", {31'd0, ex_ready}, 32'd1);
        @(posedge clk); #1;

        // ALU result is a single-cycle pulse.
        drive(2'b00, 4'd3, 16'h1234, 1'b1, 16'h0, 1'b0, 1);
        @(negedge clk);
        chk("alu_t1_en", {31'd0, wb_en}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("alu_t2_en", {31'd0, wb_en}, 32'd0);
        @(posedge clk); #1;

        // Store then load of the same word; address must stay latched.
        drive(2'b10, 4'd0, 16'h0040, 1'b0, 16'hBEEF, 1'b1, 1);
        drive(2'b01, 4'd2, 16'h0040, 1'b0, 16'h0, 1'b0, 1);
        ex_value = 16'h0099;
        @(negedge clk);
        chk("ld_t1_ready", {31'd0, ex_ready}, 32'd0);
        chk("ld_t1_busy", {31'd0, busy}, 32'd1);
        chk("ld_t1_addr", {16'd0, mem_addr}, 32'h0040);
        chk("ld_t1_wren", {31'd0, mem_wren}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("ld_t2_ready", {31'd0, ex_ready}, 32'd1);
        chk("ld_t2_busy", {31'd0, busy}, 32'd0);
        chk("ld_t2_en", {31'd0, wb_en}, 32'd1);
        @(posedge clk); #1;

        // Load followed by a held ALU op: retire in order.
        drive(2'b01, 4'd2, 16'h0040, 1'b0, 16'h0, 1'b0, 1);
        drive(2'b00, 4'd5, 16'h0007, 1'b1, 16'h0, 1'b0, 1);

        // Reset during LD_WAIT abandons the load (nothing pushed).
        drive(2'b01, 4'd3, 16'h0041, 1'b0, 16'h0, 1'b0, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("ldrst_busy", {31'd0, busy}, 32'd0);
        chk("ldrst_wb_en", {31'd0, wb_en}, 32'd0);
        chk("ldrst_ready", {31'd0, ex_ready}, 32'd1);
        chk("ldrst_wren", {31'd0, mem_wren}, 32'd0);
        repeat (3) @(posedge clk);
        #1;

        // Table-driven back-to-back traffic.
        for (int i = 0; i < 11; i++)
            drive(tbl[i].op, tbl[i].dest, tbl[i].value, tbl[i].wen,
                  tbl[i].sdata, tbl[i].exp_wren, 1);

        repeat (4) @(posedge clk);
        #1;
        chk("drain_empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
